cmip_rst_seq: RTL and testbench

CMIP_RST_SEQ -- requirements
Module: cmip_rst_seq

---
 rtl/cmip_rst_seq.sv | 177 +++++++++++++++++
 tb/tb_cmip_rst_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmip_rst_seq.sv
// rtl/cmip_rst_seq.sv - staged reset release sequencer; optional ack timeout via CMIP_RST_SEQ_TIMEOUT_EN
module cmip_rst_seq #(
    parameter int STAGE_NUM   = 4,
    parameter int STAGE_DLY   = 1000,
    parameter int HOLD_CYC    = 16,
    parameter int ACK_TIMEOUT = 65535
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_pll_locked,
    input  logic                 i_soft_rst,
    input  logic [STAGE_NUM-1:0] i_stage_ack,
    output logic [STAGE_NUM-1:0] o_rst_n,
    output logic                 o_done,
    output logic                 o_busy,
    output logic                 o_timeout
);
    localparam int               IDX_W     = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(STAGE_NUM - 1);
    localparam logic [15:0]      DLY_LOAD  = 16'(STAGE_DLY - 1);
    localparam logic [15:0]      HOLD_LOAD = 16'(HOLD_CYC - 1);

    // Reject out-of-range configurations at elaboration
    if (STAGE_NUM < 1 || STAGE_NUM > 16) begin : g_bad_stage_num
        $error("STAGE_NUM out of range");
    end
    if (STAGE_DLY < 1 || STAGE_DLY > 65535) begin : g_bad_stage_dly
        $error("STAGE_DLY out of range");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 65535) begin : g_bad_hold_cyc
        $error("HOLD_CYC out of range");
    end
    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_bad_ack_timeout
        $error("ACK_TIMEOUT out of range");
    end

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_DLY,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          hold_q, hold_d;
    logic [STAGE_NUM-1:0] rst_n_q, rst_n_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 abort;
    logic                 ack_sel;

`ifdef CMIP_RST_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LOAD = 16'(ACK_TIMEOUT - 1);
    logic timeout_q, timeout_d;
`endif

    // Lock loss only matters once sequencing has started; soft reset aborts anywhere
    assign abort   = i_soft_rst ||
                     (!i_pll_locked && (state_q == ST_DLY || state_q == ST_WAIT_ACK || state_q == ST_DONE));
    assign ack_sel = i_stage_ack[idx_q];

    // Next-state and next-output logic; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        rst_n_d = rst_n_q;
        done_d  = done_q;
`ifdef CMIP_RST_SEQ_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        if (abort) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_LOAD;
            rst_n_d = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_q == 16'd0) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        hold_d = hold_q - 16'd1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (i_pll_locked) begin
                        state_d = ST_DLY;
                        cnt_d   = DLY_LOAD;
                        idx_d   = '0;
                    end
                end
                ST_DLY: begin
                    if (cnt_q == 16'd0) begin
                        rst_n_d[idx_q] = 1'b1;
                        state_d        = ST_WAIT_ACK;
`ifdef CMIP_RST_SEQ_TIMEOUT_EN
                        cnt_d          = TO_LOAD;
`endif
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_sel) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            cnt_d   = DLY_LOAD;
                            state_d = ST_DLY;
                        end
                    end
`ifdef CMIP_RST_SEQ_TIMEOUT_EN
                    else if (cnt_q == 16'd0) begin
                        timeout_d = 1'b1;
                        state_d   = ST_HOLD;
                        hold_d    = HOLD_LOAD;
                        rst_n_d   = '0;
                        done_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
`endif
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_HOLD;
            endcase
        end
        busy_d = (state_d != ST_DONE);
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_HOLD;
            idx_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= HOLD_LOAD;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

`ifdef CMIP_RST_SEQ_TIMEOUT_EN
    // Sticky timeout flag, cleared only by the block reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_rst_n = rst_n_q;
    assign o_done  = done_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_cmip_rst_seq.sv
// tb/tb_cmip_rst_seq.sv - randomized model-checked bench for cmip_rst_seq
module tb_cmip_rst_seq;
    localparam int STAGE_NUM   = 4;
    localparam int STAGE_DLY   = 8;
    localparam int HOLD_CYC    = 4;
    localparam int ACK_TIMEOUT = 32;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic                 i_pll_locked;
    logic                 i_soft_rst;
    logic [STAGE_NUM-1:0] i_stage_ack;
    logic [STAGE_NUM-1:0] o_rst_n;
    logic                 o_done;
    logic                 o_busy;
    logic                 o_timeout;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    cmip_rst_seq #(
        .STAGE_NUM  (STAGE_NUM),
        .STAGE_DLY  (STAGE_DLY),
        .HOLD_CYC   (HOLD_CYC),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_pll_locked(i_pll_locked),
        .i_soft_rst  (i_soft_rst),
        .i_stage_ack (i_stage_ack),
        .o_rst_n     (o_rst_n),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural model: counts of released and acked stages plus elapsed-edge timers
    int m_hold;
    bit m_armed;
    int m_released;
    int m_acked;
    int m_since;
    int m_waited;
    bit m_timeout;

    task automatic m_abort();
        m_hold     = HOLD_CYC;
        m_armed    = 1'b0;
        m_released = 0;
        m_acked    = 0;
        m_since    = 0;
        m_waited   = 0;
    endtask

    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            m_abort();
            m_timeout = 1'b0;
        end else if (i_soft_rst || (m_armed && !i_pll_locked)) begin
            m_abort();
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (!m_armed) begin
            if (i_pll_locked) begin
                m_armed = 1'b1;
                m_since = 0;
            end
        end else if (m_acked == STAGE_NUM) begin
            m_since = m_since;
        end else if (m_released == m_acked) begin
            m_since++;
            if (m_since == STAGE_DLY) begin
                m_released++;
                m_waited = 0;
            end
        end else if (i_stage_ack[m_acked]) begin
            m_acked++;
            m_since = 0;
        end else begin
            m_waited++;
`ifdef CMIP_RST_SEQ_TIMEOUT_EN
            if (m_waited == ACK_TIMEOUT) begin
                m_timeout = 1'b1;
                m_abort();
            end
`endif
        end
    end

    function automatic logic [STAGE_NUM-1:0] exp_rst();
        return STAGE_NUM'((1 << m_released) - 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled on the inactive edge
    always @(negedge i_clk) begin
        if (chk_on) begin
            check("rst_n", 32'(o_rst_n), 32'(exp_rst()));
            check("done", 32'(o_done), 32'(m_acked == STAGE_NUM));
            check("busy", 32'(o_busy), 32'(m_acked != STAGE_NUM));
            check("timeout", 32'(o_timeout), 32'(m_timeout));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic lit(input string tag, input logic [STAGE_NUM-1:0] rst, input logic done);
        check({tag, "_rst"}, 32'(o_rst_n), 32'(rst));
        check({tag, "_mdl"}, 32'(exp_rst()), 32'(rst));
        check({tag, "_done"}, 32'(o_done), 32'(done));
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_pll_locked = 1'b1;
        i_soft_rst   = 1'b0;
        i_stage_ack  = '1;
        step(3);
        chk_on = 1'b1;
        lit("reset", 4'b0000, 1'b0);
        check("reset_busy", 32'(o_busy), 32'd1);

        // Straight run, acks tied high
        i_rst_n = 1'b1;
        step(13); lit("seq_s0", 4'b0001, 1'b0);
        step(9);  lit("seq_s1", 4'b0011, 1'b0);
        step(9);  lit("seq_s2", 4'b0111, 1'b0);
        step(9);  lit("seq_s3", 4'b1111, 1'b0);
        step(1);  lit("seq_done", 4'b1111, 1'b1);
        check("seq_busy", 32'(o_busy), 32'd0);

        // One-cycle lock drop in DONE
        i_pll_locked = 1'b0;
        step(1);
        i_pll_locked = 1'b1;
        lit("lock_abort", 4'b0000, 1'b0);
        check("lock_busy", 32'(o_busy), 32'd1);
        step(4);  lit("lock_hold", 4'b0000, 1'b0);
        step(9);  lit("lock_s0", 4'b0001, 1'b0);
        step(28); lit("lock_done", 4'b1111, 1'b1);

`ifndef CMIP_RST_SEQ_TIMEOUT_EN
        // Withheld stage-1 ack
        i_soft_rst  = 1'b1;
        i_stage_ack = 4'b1101;
        step(1);
        i_soft_rst = 1'b0;
        lit("wack_abort", 4'b0000, 1'b0);
        step(22); lit("wack_s1", 4'b0011, 1'b0);
        step(50); lit("wack_wait", 4'b0011, 1'b0);
        i_stage_ack = 4'b1111;
        step(8);  lit("wack_pre", 4'b0011, 1'b0);
        step(1);  lit("wack_s2", 4'b0111, 1'b0);
        step(10); lit("wack_done", 4'b1111, 1'b1);
`endif

        // Soft reset on the same edge as the stage-2 ack
        i_soft_rst  = 1'b1;
        i_stage_ack = 4'b1011;
        step(1);
        i_soft_rst = 1'b0;
        step(31); lit("race_s2", 4'b0111, 1'b0);
        step(1);
        i_soft_rst  = 1'b1;
        i_stage_ack = 4'b1111;
        step(1);
        i_soft_rst = 1'b0;
        lit("race_abort", 4'b0000, 1'b0);
        step(41); lit("race_done", 4'b1111, 1'b1);

        // Block reset mid-sequence
        i_soft_rst = 1'b1;
        step(1);
        i_soft_rst = 1'b0;
        step(22); lit("mid_s1", 4'b0011, 1'b0);
        i_rst_n = 1'b0;
        step(1);
        lit("mid_reset", 4'b0000, 1'b0);
        check("mid_busy", 32'(o_busy), 32'd1);
        check("mid_timeout", 32'(o_timeout), 32'd0);
        i_rst_n = 1'b1;

`ifdef CMIP_RST_SEQ_TIMEOUT_EN
        // Ack timeout on stage 0, flag sticky through re-sequence
        i_stage_ack = 4'b1110;
        step(44);
        lit("to_pre", 4'b0001, 1'b0);
        check("to_pre_flag", 32'(o_timeout), 32'd0);
        step(1);
        lit("to_fire", 4'b0000, 1'b0);
        check("to_fire_flag", 32'(o_timeout), 32'd1);
        i_stage_ack = 4'b1111;
        step(41);
        lit("to_redone", 4'b1111, 1'b1);
        check("to_sticky", 32'(o_timeout), 32'd1);
        i_rst_n = 1'b0;
        step(1);
        check("to_clear", 32'(o_timeout), 32'd0);
        i_rst_n = 1'b1;
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1);
            i_rst_n      = ($urandom_range(0, 599) != 0);
            i_pll_locked = ($urandom_range(0, 149) != 0);
            i_soft_rst   = ($urandom_range(0, 249) == 0);
            i_stage_ack  = 4'($urandom_range(0, 15));
        end

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
